// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter and its receiver.
package uart_pkg;

  // Parity modes for the PARITY build parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Frame-level FSM encoding shared by TX and RX
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

  // Number of sys_clk cycles per UART bit (integer division)
  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_baud_gen.sv
// Bit-period timer: counts 0..CNT_MAX-1 while enabled, held at 0 otherwise.
// The strobe marks the last cycle of each bit, or the middle of the bit when
// MID_STROBE is set (receiver sampling point).
module uart_baud_gen #(
  parameter int CNT_MAX    = 10,
  parameter bit MID_STROBE = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en_i,
  output logic bit_stb_o
);

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CNT_MAX / 2);

  logic [CNT_W-1:0] baud_cnt_q;
  logic [CNT_W-1:0] baud_cnt_d;
  logic             bit_end;

  assign bit_end = (baud_cnt_q == CNT_LAST);

  // Next count: hold at zero when disabled, wrap at the end of each bit
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    if (!en_i) begin
      baud_cnt_d = '0;
    end else if (bit_end) begin
      baud_cnt_d = '0;
    end else begin
      baud_cnt_d = baud_cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
    end
  end

  assign bit_stb_o = MID_STROBE ? (baud_cnt_q == CNT_MID) : bit_end;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS data bits (LSB first), optional
// odd/even parity and one or two stop bits, with a valid/ready input handshake.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int UART_BPS  = 9600,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [DATA_BITS-1:0] pi_data,
  input  logic                 pi_flag,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  // Build-time parameter sanity
  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (BAUD_CNT_MAX < 2) begin : g_bad_baud
      $error("uart_tx_cfg: CLK_FREQ/UART_BPS must be at least 2");
    end
  endgenerate

  uart_state_e            state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;
  logic                   last_stop;

  // Bit timer runs for the whole frame and rests at zero in IDLE
  uart_baud_gen #(
    .CNT_MAX    (BAUD_CNT_MAX),
    .MID_STROBE (1'b0)
  ) u_baud_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en_i      (state_q != IDLE),
    .bit_stb_o (bit_end)
  );

  assign last_stop = (stop_idx_q == STOP_LAST);

  // Next-state, datapath and serial-line value for the next cycle
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        if (pi_flag) begin
          state_d    = START;
          shreg_d    = pi_data;
          par_d      = (PARITY == PAR_ODD) ? ~^pi_data : ^pi_data;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d   = shreg_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level follows the state being entered so tx changes with it
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // Frame state and serial-line register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = (state_q == STOP) && bit_end && last_stop;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four build configurations at 10 cycles/bit.
module tb_uart_tx_cfg;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BPS      = 5_000_000;
  localparam int BIT_CYC  = 10;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [7:0] pd8 [3];
  logic [6:0] pd7;
  logic       pi_flag  [4];
  logic       tx_ready [4];
  logic       tx_busy  [4];
  logic       tx_done  [4];
  logic       tx       [4];

  int checks   = 0;
  int failures = 0;

  uart_tx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pd8[0]), .pi_flag(pi_flag[0]),
    .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .tx(tx[0]));

  uart_tx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pd8[1]), .pi_flag(pi_flag[1]),
    .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .tx(tx[1]));

  uart_tx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pd8[2]), .pi_flag(pi_flag[2]),
    .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .tx(tx[2]));

  uart_tx_cfg #(.UART_BPS(BPS), .CLK_FREQ(CLK_FREQ), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_data(pd7), .pi_flag(pi_flag[3]),
    .tx_ready(tx_ready[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]), .tx(tx[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic [7:0] d);
    if (inst == 3) pd7 = d[6:0];
    else           pd8[inst] = d;
  endtask

  // Send one frame on instance inst and check every cycle of it.
  // hold keeps pi_flag high after acceptance; inject_at raises a second
  // request with 8'hFF at that cycle; abort_at asserts reset at that cycle.
  task automatic run_frame(input int inst, input logic [7:0] data, input int nbits,
                           input int par, input int nstop, input bit hold,
                           input int inject_at, input int abort_at, input string tag);
    logic fb [16];
    int   nb;
    int   ones;
    int   len;
    nb = 0;
    ones = 0;
    fb[nb] = 1'b0; nb++;
    for (int i = 0; i < nbits; i++) begin
      fb[nb] = data[i]; nb++;
      if (data[i]) ones++;
    end
    if (par == 1) begin fb[nb] = (ones % 2 == 0); nb++; end
    if (par == 2) begin fb[nb] = (ones % 2 == 1); nb++; end
    for (int i = 0; i < nstop; i++) begin fb[nb] = 1'b1; nb++; end
    len = nb * BIT_CYC;

    @(negedge sys_clk);
    check($sformatf("%s_idle_ready", tag), 32'(tx_ready[inst]), 32'd1);
    check($sformatf("%s_idle_tx", tag),    32'(tx[inst]),       32'd1);
    check($sformatf("%s_idle_busy", tag),  32'(tx_busy[inst]),  32'd0);
    check($sformatf("%s_idle_done", tag),  32'(tx_done[inst]),  32'd0);
    drive(inst, data);
    pi_flag[inst] = 1'b1;
    @(posedge sys_clk);
    #1;
    if (!hold) begin
      pi_flag[inst] = 1'b0;
      drive(inst, ~data);
    end

    for (int k = 1; k <= len; k++) begin
      @(negedge sys_clk);
      if (k == abort_at) begin
        #1 sys_rst_n = 1'b0;
        #1;
        check($sformatf("%s_rst_tx", tag),    32'(tx[inst]),       32'd1);
        check($sformatf("%s_rst_ready", tag), 32'(tx_ready[inst]), 32'd1);
        check($sformatf("%s_rst_busy", tag),  32'(tx_busy[inst]),  32'd0);
        check($sformatf("%s_rst_done", tag),  32'(tx_done[inst]),  32'd0);
        return;
      end
      check($sformatf("%s_tx_c%0d", tag, k),    32'(tx[inst]),       32'(fb[(k-1)/BIT_CYC]));
      check($sformatf("%s_busy_c%0d", tag, k),  32'(tx_busy[inst]),  32'd1);
      check($sformatf("%s_ready_c%0d", tag, k), 32'(tx_ready[inst]), 32'd0);
      check($sformatf("%s_done_c%0d", tag, k),  32'(tx_done[inst]),  32'(k == len));
      if (inject_at > 0 && k == inject_at) begin
        pi_flag[inst] = 1'b1;
        drive(inst, 8'hFF);
      end else if (inject_at > 0 && k == inject_at + 1) begin
        pi_flag[inst] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) pd8[i] = '0;
    pd7 = '0;
    for (int i = 0; i < 4; i++) pi_flag[i] = 1'b0;

    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_tx%0d", i),    32'(tx[i]),       32'd1);
      check($sformatf("reset_ready%0d", i), 32'(tx_ready[i]), 32'd1);
      check($sformatf("reset_busy%0d", i),  32'(tx_busy[i]),  32'd0);
      check($sformatf("reset_done%0d", i),  32'(tx_done[i]),  32'd0);
    end
    sys_rst_n = 1'b1;

    run_frame(0, 8'hA5, 8, 0, 1, 1'b0, 0, 0, "8n1_a5");
    run_frame(1, 8'h07, 8, 2, 1, 1'b0, 0, 0, "8e1_07");
    run_frame(2, 8'h07, 8, 1, 1, 1'b0, 0, 0, "8o1_07");
    run_frame(3, 8'h41, 7, 0, 2, 1'b0, 0, 0, "7n2_41");

    // Request during a frame is ignored; only 8'h55 goes out
    run_frame(0, 8'h55, 8, 0, 1, 1'b0, 30, 0, "ign_55");

    // pi_flag held high: frames follow each other, one ready cycle between
    run_frame(0, 8'h3C, 8, 0, 1, 1'b1, 0, 0, "b2b1_3c");
    run_frame(0, 8'h3C, 8, 0, 1, 1'b1, 0, 0, "b2b2_3c");
    run_frame(0, 8'h3C, 8, 0, 1, 1'b0, 0, 0, "b2b3_3c");

    // Reset in the middle of a frame, then a clean frame
    run_frame(0, 8'hC3, 8, 0, 1, 1'b0, 0, 45, "abort_c3");
    @(negedge sys_clk);
    check("abort_held_tx", 32'(tx[0]), 32'd1);
    sys_rst_n = 1'b1;
    run_frame(0, 8'h81, 8, 0, 1, 1'b0, 0, 0, "post_rst_81");

    @(negedge sys_clk);
    check("final_ready", 32'(tx_ready[0]), 32'd1);
    check("final_tx",    32'(tx[0]),       32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
